// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: "1011" preamble, MSB-first payload, optional even parity, guard zero.
// All outputs are registered so the serial line is glitch-free.
module seq_frame_tx #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       PREAMBLE = 4'b1011;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StData,
        StPar,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               out_q, out_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        out_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid && ready_q) begin
                    shift_d   = data_in;
                    parity_d  = ^data_in;
                    pre_cnt_d = 2'd0;
                    state_d   = StPre;
                    out_d     = PREAMBLE[3];
                end
            end
            StPre: begin
                if (pre_cnt_q == 2'd3) begin
                    // Present the MSB now; the register keeps only the bits still to send.
                    state_d   = StData;
                    bit_cnt_d = '0;
                    out_d     = shift_q[DATA_W-1];
                    shift_d   = shift_q << 1;
                end else begin
                    pre_cnt_d = pre_cnt_q + 2'd1;
                    out_d     = PREAMBLE[2'd3 - pre_cnt_d];
                end
            end
            StData: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (PARITY_EN != 0) begin
                        state_d = StPar;
                        out_d   = parity_q;
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    out_d     = shift_q[DATA_W-1];
                    shift_d   = shift_q << 1;
                end
            end
            StPar: begin
                state_d = StGap;
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d      = (state_d == StIdle);
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StGap);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            pre_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            out_q        <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            out_q        <= out_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ready      = ready_q;
    assign out        = out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: a default instance plus a parity-disabled instance,
// compared cycle by cycle against a frame model built from the bit-level frame layout.
module tb_seq_frame_tx;

    typedef logic [3:0] stat_t;  // {out, busy, ready, frame_done}
    typedef stat_t stat_q_t[$];

    localparam stat_t IDLE_ST = 4'b0010;

    logic       clk = 1'b0;
    logic       rst, valid, valid2;
    logic [7:0] data_in, data2;
    logic       ready, out, busy, frame_done;
    logic       ready2, out2, busy2, frame_done2;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    seq_frame_tx #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid     (valid),
        .ready     (ready),
        .out       (out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    seq_frame_tx #(.DATA_W(8), .PARITY_EN(0)) dut_np (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data2),
        .valid     (valid2),
        .ready     (ready2),
        .out       (out2),
        .busy      (busy2),
        .frame_done(frame_done2)
    );

    // Expected per-cycle status starting the cycle after the handshake.
    function automatic stat_q_t frame_status(input logic [7:0] d, input bit par_en);
        stat_q_t q;
        bit      bits[$];
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
        if (par_en) bits.push_back(($countones(d) % 2) == 1);
        bits.push_back(1'b0);
        foreach (bits[i]) q.push_back({bits[i], 1'b1, 1'b0, (i == bits.size() - 1)});
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (ready !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_idle: ready=%b after %0d cycles, required 1", ready, k);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        valid   = 1'b1;
        data_in = 8'hFF;
        repeat (3) begin
            tick();
            n_checks++;
            if ({out, busy, ready, frame_done} !== IDLE_ST) begin
                n_fail++;
                $display("FAIL reset_state: got %b required %b", {out, busy, ready, frame_done},
                         IDLE_ST);
            end
        end
        valid = 1'b0;
        rst   = 1'b1;
        tick();
        n_checks++;
        if ({out, busy, ready, frame_done} !== IDLE_ST) begin
            n_fail++;
            $display("FAIL reset_release: got %b required %b", {out, busy, ready, frame_done},
                     IDLE_ST);
        end
    endtask

    task automatic test_single_frame();
        stat_q_t exp;
        wait_idle();
        exp     = frame_status(8'hA5, 1'b1);
        data_in = 8'hA5;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        exp.push_back(IDLE_ST);
        foreach (exp[i]) begin
            n_checks++;
            if ({out, busy, ready, frame_done} !== exp[i]) begin
                n_fail++;
                $display("FAIL single_frame cyc %0d: got %b required %b", i + 1,
                         {out, busy, ready, frame_done}, exp[i]);
            end
            data_in = 8'($urandom);
            tick();
        end
    endtask

    task automatic test_parity();
        stat_q_t exp;
        wait_idle();
        exp = frame_status(8'h01, 1'b1);
        exp.push_back(IDLE_ST);
        exp = {exp, frame_status(8'h00, 1'b1)};
        data_in = 8'h01;
        valid   = 1'b1;
        tick();
        data_in = 8'h00;
        foreach (exp[i]) begin
            n_checks++;
            if ({out, busy, ready, frame_done} !== exp[i]) begin
                n_fail++;
                $display("FAIL parity_b2b cyc %0d: got %b required %b", i + 1,
                         {out, busy, ready, frame_done}, exp[i]);
            end
            tick();
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_ignored_valid();
        stat_q_t exp;
        wait_idle();
        exp     = frame_status(8'h3C, 1'b1);
        data_in = 8'h3C;
        valid   = 1'b1;
        tick();
        foreach (exp[i]) begin
            n_checks++;
            if ({out, busy, ready, frame_done} !== exp[i]) begin
                n_fail++;
                $display("FAIL ignored_valid cyc %0d: got %b required %b", i + 1,
                         {out, busy, ready, frame_done}, exp[i]);
            end
            if (i < 12) begin
                valid   = 1'($urandom);
                data_in = 8'hC3;
            end else begin
                valid = 1'b0;
            end
            tick();
        end
        repeat (16) begin
            n_checks++;
            if (busy !== 1'b0 || out !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_valid_extra: busy=%b out=%b required 0 0", busy, out);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        stat_q_t exp;
        int      pulses = 0;
        wait_idle();
        exp     = frame_status(8'hF0, 1'b1);
        data_in = 8'hF0;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({out, busy, ready, frame_done} !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc %0d: got %b required %b", i + 1,
                         {out, busy, ready, frame_done}, exp[i]);
            end
            if (i == 6) rst = 1'b0;
            tick();
        end
        rst = 1'b1;
        n_checks++;
        if ({out, busy, ready, frame_done} !== IDLE_ST) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b required %b", {out, busy, ready, frame_done},
                     IDLE_ST);
        end
        repeat (20) begin
            tick();
            if (frame_done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: %0d busy/done cycles, required 0", pulses);
        end
        exp     = frame_status(8'h96, 1'b1);
        data_in = 8'h96;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        foreach (exp[i]) begin
            n_checks++;
            if ({out, busy, ready, frame_done} !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_mid_next cyc %0d: got %b required %b", i + 1,
                         {out, busy, ready, frame_done}, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_no_parity();
        stat_q_t exp;
        exp = frame_status(8'hFF, 1'b0);
        exp.push_back(IDLE_ST);
        data2  = 8'hFF;
        valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        foreach (exp[i]) begin
            n_checks++;
            if ({out2, busy2, ready2, frame_done2} !== exp[i]) begin
                n_fail++;
                $display("FAIL no_parity cyc %0d: got %b required %b", i + 1,
                         {out2, busy2, ready2, frame_done2}, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        stat_q_t    exp;
        logic [7:0] d;
        for (int f = 0; f < 20; f++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
            d       = 8'($urandom);
            exp     = frame_status(d, 1'b1);
            data_in = d;
            valid   = 1'b1;
            tick();
            valid = 1'b0;
            foreach (exp[i]) begin
                n_checks++;
                if ({out, busy, ready, frame_done} !== exp[i]) begin
                    n_fail++;
                    $display("FAIL random d=%h cyc %0d: got %b required %b", d, i + 1,
                             {out, busy, ready, frame_done}, exp[i]);
                end
                data_in = 8'($urandom);
                tick();
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        valid   = 1'b0;
        valid2  = 1'b0;
        data_in = 8'h00;
        data2   = 8'h00;
        test_reset();
        test_single_frame();
        test_parity();
        test_ignored_valid();
        test_reset_mid();
        test_no_parity();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter. It is the sending end of the "1011" sync-pattern link, whose receiving end is the overlapping Moore detector. The block accepts a parallel word over a valid/ready handshake and drives it onto a single serial line, one bit per clock: a fixed "1011" preamble, then the data bits MSB-first, then an optional even-parity bit, then one guard zero. All outputs are registered (Moore-style), so the line never glitches within a cycle.

## Interface
Parameters:
- DATA_W, default 8: payload width in bits; legal range 1–32.
- PARITY_EN, default 1: 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- data_in  input  DATA_W  payload word; sampled only on a handshake edge.
- valid  input  1  producer has a word on data_in.
- ready  output  1  block can accept a word; registered.
- out  output  1  serial line; registered; 0 when idle.
- busy  output  1  high from the cycle after a handshake through the guard cycle; registered.
- frame_done  output  1  one-cycle pulse during the guard cycle; registered.

## Operation
- States: IDLE, PRE, DATA, PAR, GAP.
  - A 2-bit counter indexes the preamble bits.
  - A counter of width ceil(log2(DATA_W)) indexes the data bits.
- IDLE
  - Outputs: out=0, ready=1, busy=0.
  - On valid && ready at an edge: capture data_in into the shift register, compute even parity (XOR of all data bits), go to PRE, and load out with 1.
- PRE: out emits 1, 0, 1, 1 on four consecutive cycles, then goes to DATA.
- DATA
  - out emits the shift register MSB-first for DATA_W cycles.
  - After the last data bit, go to PAR if PARITY_EN=1, otherwise go to GAP.
- PAR: out equals the captured parity bit for 1 cycle, so the total count of ones in data+parity is even. Then go to GAP.
- GAP: out=0 and frame_done=1 for 1 cycle, then go to IDLE.
- ready is 1 only in IDLE. valid seen while ready=0 is ignored; it is neither queued nor latched.
- data_in may change freely after the handshake. The transmitted frame uses only the captured value.
- The payload is not scrubbed: data containing "1011" can produce a detector hit. Framing above this block is responsible for that.

## Timing
- Reset: on any edge with rst=0, the next cycle shows state=IDLE, out=0, ready=1, busy=0, frame_done=0, and counters and shift register cleared.
  - This applies mid-frame: the frame is aborted, the word is discarded, and no frame_done is produced.
  - When rst and valid are both active on the same edge, reset wins and the word is not accepted.
- Latency: handshake at edge E means the first preamble bit appears on out in the cycle after E.
- Frame length on out: 4 + DATA_W + PARITY_EN + 1 cycles, i.e. 14 cycles for the defaults.
- Back-to-back: the IDLE cycle is mandatory between frames. With valid held high, handshakes occur every 4 + DATA_W + PARITY_EN + 2 cycles (15 for the defaults). Between frames out is 0 for 2 cycles (GAP, then IDLE).
- busy = 1 exactly during the PRE, DATA, PAR and GAP cycles. frame_done = 1 exactly during the GAP cycle.

## Test plan
- Reset values: hold rst=0 for 3 edges with valid=1 and data_in=0xFF. Required: out=0, ready=1, busy=0, frame_done=0 throughout, and no frame starts.
- Single frame, defaults: send data_in=0xA5. Required: out = 1,0,1,1, 1,0,1,0,0,1,0,1, 0 (parity), 0 (guard). frame_done is high on the 14th cycle only, and ready returns to 1 on the 15th.
- Parity check: send 0x01, then 0x00 with valid held high. Required:
  - Parity bits are 1 and then 0.
  - Second preamble starts 15 cycles after the first.
  - out=0 on the 2 cycles between the frames.
- Ignored valid: while a frame for 0x3C is busy, toggle valid and change data_in to 0xC3. Required: transmitted data bits are 00111100, and exactly one frame is sent.
- Reset mid-frame: assert rst=0 on the 3rd data bit of 0xF0. Required:
  - out=0 and ready=1 the cycle after the reset edge.
  - No frame_done pulse.
  - The next accepted word transmits a complete frame.
- PARITY_EN=0, DATA_W=8: send 0xFF. Required: out = 1,0,1,1, eight 1s, then 0 (guard). The frame lasts 13 cycles, and frame_done is on cycle 13.
